add_arbiter: RTL and testbench

Shares the single 64-bit carry-lookahead `ADD` datapath among `N_REQ` independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request, the block registers that request's operands into `ADD`, and the registered sum, carry and signed-overflow flag are returned on one response channel tagged with the requester id. The block sits between the scalar issue logic and the shared adder, and is the only module that drives `ADD` inputs.

---
 rtl/add_arb_pkg.sv | 15 +
 rtl/ADD.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/add_arbiter.sv | 147 ++++++++++++++
 tb/tb_add_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and sizes for the add_arbiter block: FSM state encoding,
// datapath width, overflow counter width and default requester count.
package add_arb_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned OVF_CNT_W = 16;
  localparam int unsigned N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ADD.sv
// 64-bit carry-lookahead adder.
// Ports: input1/input2 operands, c_in carry-in; out sum, carry_out unsigned
// carry from bit 63, overflow_check signed two's-complement overflow.
module ADD (
  input  logic [63:0] input1,
  input  logic [63:0] input2,
  input  logic        c_in,
  output logic [63:0] out,
  output logic        carry_out,
  output logic        overflow_check
);

  logic [63:0] gen;
  logic [63:0] prop;
  logic [64:0] carry;

  // Per-bit generate/propagate and the carry recurrence built from them.
  always_comb begin
    gen      = input1 & input2;
    prop     = input1 ^ input2;
    carry    = '0;
    carry[0] = c_in;
    for (int i = 0; i < 64; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign out            = prop ^ carry[63:0];
  assign carry_out      = carry[64];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow_check = carry[64] ^ carry[63];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// wrapping at N_REQ.
// Ports: req_valid, rr_ptr in; grant_onehot, grant_id, any out.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_id,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    grant_onehot = '0;
    grant_id     = '0;
    any          = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req_valid[ID_W'(idx)]) begin
        any                        = 1'b1;
        grant_id                   = ID_W'(idx);
        grant_onehot[ID_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one 64-bit ADD datapath among N_REQ valid/ready requesters.
// Round-robin grant in IDLE, operands registered into ADD during CALC,
// registered result held on the response channel in RESP until accepted.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b/
// req_cin per requester; resp_valid/resp_ready/resp_id/resp_sum/resp_carry/
// resp_ovf response channel; ovf_count saturating overflow-response count.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_cin,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [DATA_W-1:0]       resp_sum,
  output logic                    resp_carry,
  output logic                    resp_ovf,
  output logic [OVF_CNT_W-1:0]    ovf_count
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic                  cin_q, cin_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_W-1:0]     sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic                  ovf_q, ovf_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [OVF_CNT_W-1:0]  ovf_count_q, ovf_count_d;

  logic [N_REQ-1:0]      grant_onehot;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_any;
  logic [DATA_W-1:0]     add_out;
  logic                  add_carry;
  logic                  add_ovf;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req_valid    (req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any          (grant_any)
  );

  ADD u_add (
    .input1         (a_q),
    .input2         (b_q),
    .c_in           (cin_q),
    .out            (add_out),
    .carry_out      (add_carry),
    .overflow_check (add_ovf)
  );

  // Ready is only offered in IDLE and is forced low while reset is held.
  assign req_ready = (state_q == S_IDLE && !rst) ? grant_onehot : '0;

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    ovf_d        = ovf_q;
    resp_valid_d = resp_valid_q;
    ovf_count_d  = ovf_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          a_d      = req_a[32'(grant_id)*DATA_W +: DATA_W];
          b_d      = req_b[32'(grant_id)*DATA_W +: DATA_W];
          cin_d    = req_cin[grant_id];
          id_d     = grant_id;
          rr_ptr_d = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        sum_d        = add_out;
        carry_d      = add_carry;
        ovf_d        = add_ovf;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
          if (ovf_q && ovf_count_q != '1) begin
            ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      ovf_q        <= ovf_d;
      resp_valid_q <= resp_valid_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_carry = carry_q;
  assign resp_ovf   = ovf_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: per-requester operation queues drive
// the request side; a transaction-level model predicts grants, results and
// the overflow counter every cycle.
module tb_add_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
  } op_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*64-1:0]  req_a = '0;
  logic [N*64-1:0]  req_b = '0;
  logic [N-1:0]     req_cin = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [IDW-1:0]   resp_id;
  logic [63:0]      resp_sum;
  logic             resp_carry;
  logic             resp_ovf;
  logic [15:0]      ovf_count;

  add_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .resp_ovf   (resp_ovf),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  // Model state: phase 0 = waiting for a grant, 1 = computing, 2 = result out.
  op_t         q[N][$];
  int          mphase = 0;
  int          mptr   = 0;
  int          gk     = -1;
  logic [15:0] mcount = '0;
  int          e_id   = 0;
  logic [63:0] e_sum  = '0;
  logic        e_carry = 1'b0;
  logic        e_ovf   = 1'b0;
  int          bp_cnt = 0;
  bit          rnd_rdy = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic cin);
    op_t op;
    op.a = a; op.b = b; op.cin = cin;
    q[k].push_back(op);
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'(0);
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  function automatic logic [63:0] busy();
    logic b;
    b = (mphase != 0);
    for (int k = 0; k < N; k++) if (q[k].size() != 0) b = 1'b1;
    return 64'(b);
  endfunction

  // Round-robin choice from the model's own pointer and the pending queues.
  task automatic pick();
    gk = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mptr + i) % N;
      if (gk < 0 && q[k].size() != 0) gk = k;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = (q[k].size() != 0);
      if (q[k].size() != 0) begin
        req_a[64*k +: 64] = q[k][0].a;
        req_b[64*k +: 64] = q[k][0].b;
        req_cin[k]        = q[k][0].cin;
      end else begin
        req_a[64*k +: 64] = '0;
        req_b[64*k +: 64] = '0;
        req_cin[k]        = 1'b0;
      end
    end
    if (mphase == 2 && bp_cnt > 0) begin
      resp_ready = 1'b0;
      bp_cnt--;
    end else begin
      resp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic check();
    logic [63:0] exp_rdy;
    pick();
    exp_rdy = (mphase == 0 && gk >= 0) ? (64'(1) << gk) : 64'(0);
    chk("req_ready", 64'(req_ready), exp_rdy);
    chk("resp_valid", 64'(resp_valid), 64'(mphase == 2));
    if (mphase == 2) begin
      chk("resp_id",    64'(resp_id),    64'(e_id));
      chk("resp_sum",   resp_sum,        e_sum);
      chk("resp_carry", 64'(resp_carry), 64'(e_carry));
      chk("resp_ovf",   64'(resp_ovf),   64'(e_ovf));
    end
    chk("ovf_count", 64'(ovf_count), 64'(mcount));
  endtask

  // Advance the model across the coming rising edge.
  task automatic step();
    op_t op;
    logic [64:0]        u;
    logic signed [65:0] s;
    case (mphase)
      0: if (gk >= 0) begin
        op      = q[gk].pop_front();
        u       = {1'b0, op.a} + {1'b0, op.b} + 65'(op.cin);
        s       = 66'($signed(op.a)) + 66'($signed(op.b)) + 66'(op.cin);
        e_id    = gk;
        e_sum   = u[63:0];
        e_carry = u[64];
        e_ovf   = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
        mptr    = (gk + 1) % N;
        mphase  = 1;
      end
      1: mphase = 2;
      default: if (resp_ready) begin
        if (e_ovf && mcount != 16'hFFFF) mcount = mcount + 16'd1;
        mphase = 0;
      end
    endcase
  endtask

  task automatic body();
    drive();
    #1;
    check();
    step();
  endtask

  task automatic cycle();
    @(negedge clk);
    body();
  endtask

  // Assert reset mid-cycle, check cleared outputs, then release and resume.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_ready",  64'(req_ready),  64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id",    64'(resp_id),    64'(0));
    chk("rst_resp_sum",   resp_sum,        64'(0));
    chk("rst_resp_carry", 64'(resp_carry), 64'(0));
    chk("rst_resp_ovf",   64'(resp_ovf),   64'(0));
    chk("rst_ovf_count",  64'(ovf_count),  64'(0));
    mphase = 0; mptr = 0; mcount = '0; bp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    body();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, busy(), 64'(0));
  endtask

  initial begin
    do_reset();

    add_op(0, 64'd5, 64'd7, 1'b0);
    drain("drain_single", 20);

    add_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain("drain_ovf", 20);

    add_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain("drain_carry", 20);

    // Round-robin from a fresh pointer: ids 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < N; k++) add_op(k, 64'(k), 64'd1, 1'b0);
    add_op(0, 64'd0, 64'd1, 1'b0);
    drain("drain_rr", 40);

    // Back-pressure with a competing requester waiting.
    bp_cnt = 10;
    add_op(2, 64'd100, -64'sd50, 1'b1);
    add_op(1, 64'd3, 64'd4, 1'b1);
    drain("drain_bp", 40);

    rnd_rdy = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        add_op(int'($urandom_range(0, N - 1)), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      end
      cycle();
    end
    drain("drain_rand", 400);
    rnd_rdy = 1'b0;

    // Reset while req2 is in CALC; req0 must win first after reset.
    add_op(2, 64'd11, 64'd22, 1'b0);
    begin
      int n;
      n = 0;
      while (mphase != 1 && n < 10) begin
        cycle();
        n++;
      end
    end
    chk("reach_calc", 64'(mphase), 64'(1));
    add_op(0, 64'd1, 64'd2, 1'b0);
    add_op(2, 64'd3, 64'd4, 1'b1);
    do_reset();
    drain("drain_after_rst", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
